// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and port-slice helpers for the multi-port register file
package regfile_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_ADDR_SIZE = 3;
    localparam int MAX_NUM_RD    = 8;

    // LSB of port k inside a flattened per-port address bus
    function automatic int addr_lsb(input int k, input int addr_size);
        return k * addr_size;
    endfunction

    // LSB of port k inside a flattened per-port data bus
    function automatic int data_lsb(input int k, input int word_size);
        return k * word_size;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with optional write bypass and zero-register mask
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] word,
    input  logic                 pend,
    input  logic                 wr_a_en,
    input  logic [ADDR_SIZE-1:0] wr_a_addr,
    input  logic [WORD_SIZE-1:0] wr_a_data,
    input  logic                 wr_b_en,
    input  logic [ADDR_SIZE-1:0] wr_b_addr,
    input  logic [WORD_SIZE-1:0] wr_b_data,
    input  logic                 rsv_en,
    input  logic [ADDR_SIZE-1:0] rsv_addr,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_pend
);

    logic                 a_hit;
    logic                 b_hit;
    logic                 r_hit;
    logic [WORD_SIZE-1:0] data_new;
    logic [WORD_SIZE-1:0] data_sel;
    logic                 pend_new;
    logic                 pend_sel;

    // The post-write view mirrors the storage update: B beats A, reserve beats any write.
    always_comb begin
        a_hit    = wr_a_en && (wr_a_addr == addr);
        b_hit    = wr_b_en && (wr_b_addr == addr);
        r_hit    = rsv_en && (rsv_addr == addr);
        data_new = b_hit ? wr_b_data : (a_hit ? wr_a_data : word);
        pend_new = r_hit ? 1'b1 : ((a_hit || b_hit) ? 1'b0 : pend);
        data_sel = (BYPASS != 0) ? data_new : word;
        pend_sel = (BYPASS != 0) ? pend_new : pend;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            data_sel = '0;
            pend_sel = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            rd_valid <= en;
            if (en) begin
                rd_data <= data_sel;
                rd_pend <= pend_sel;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read, dual-write register file with pending scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int REG_MAX   = 2 ** ADDR_SIZE,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           rdEn,
    input  logic [NUM_RD*ADDR_SIZE-1:0] rdAddr,
    output logic [NUM_RD*WORD_SIZE-1:0] rdData,
    output logic [NUM_RD-1:0]           rdValid,
    output logic [NUM_RD-1:0]           rdPending,
    input  logic                        wrtEnableA,
    input  logic [ADDR_SIZE-1:0]        wrtAddrA,
    input  logic [WORD_SIZE-1:0]        wrtDataA,
    input  logic                        wrtEnableB,
    input  logic [ADDR_SIZE-1:0]        wrtAddrB,
    input  logic [WORD_SIZE-1:0]        wrtDataB,
    input  logic                        rsvEnable,
    input  logic [ADDR_SIZE-1:0]        rsvAddr,
    output logic                        wrtConflict
);

    logic [WORD_SIZE-1:0] regs [REG_MAX];
    logic [REG_MAX-1:0]   pending;

    logic we_a;
    logic we_b;
    logic rsv;
    logic same_addr;

    // Accesses to the hard-wired zero register are discarded before any arbitration.
    always_comb begin
        we_a      = wrtEnableA && !((ZERO_REG != 0) && (wrtAddrA == '0));
        we_b      = wrtEnableB && !((ZERO_REG != 0) && (wrtAddrB == '0));
        rsv       = rsvEnable && !((ZERO_REG != 0) && (rsvAddr == '0));
        same_addr = we_a && we_b && (wrtAddrA == wrtAddrB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_MAX; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            wrtConflict <= 1'b0;
        end else begin
            if (we_a && !same_addr) begin
                regs[wrtAddrA] <= wrtDataA;
            end
            if (we_b) begin
                regs[wrtAddrB] <= wrtDataB;
            end
            // A reserve in the same cycle as a write names a new producer, so it wins.
            for (int i = 0; i < REG_MAX; i++) begin
                if (rsv && (rsvAddr == ADDR_SIZE'(i))) begin
                    pending[i] <= 1'b1;
                end else if ((we_a && (wrtAddrA == ADDR_SIZE'(i))) ||
                             (we_b && (wrtAddrB == ADDR_SIZE'(i)))) begin
                    pending[i] <= 1'b0;
                end
            end
            wrtConflict <= same_addr;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_SIZE-1:0] addr;

        assign addr = rdAddr[addr_lsb(k, ADDR_SIZE) +: ADDR_SIZE];

        regfile_rd_port #(
            .WORD_SIZE (WORD_SIZE),
            .ADDR_SIZE (ADDR_SIZE),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .en        (rdEn[k]),
            .addr      (addr),
            .word      (regs[addr]),
            .pend      (pending[addr]),
            .wr_a_en   (we_a),
            .wr_a_addr (wrtAddrA),
            .wr_a_data (wrtDataA),
            .wr_b_en   (we_b),
            .wr_b_addr (wrtAddrB),
            .wr_b_data (wrtDataB),
            .rsv_en    (rsv),
            .rsv_addr  (rsvAddr),
            .rd_data   (rdData[data_lsb(k, WORD_SIZE) +: WORD_SIZE]),
            .rd_valid  (rdValid[k]),
            .rd_pend   (rdPending[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench: two configurations driven in lockstep against a reference model
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rdEn;
    logic [11:0] rdAddr;
    logic        wrtEnableA;
    logic [2:0]  wrtAddrA;
    logic [15:0] wrtDataA;
    logic        wrtEnableB;
    logic [2:0]  wrtAddrB;
    logic [15:0] wrtDataB;
    logic        rsvEnable;
    logic [2:0]  rsvAddr;

    logic [63:0] rd_data_0,  rd_data_1;
    logic [3:0]  rd_valid_0, rd_valid_1;
    logic [3:0]  rd_pend_0,  rd_pend_1;
    logic        conflict_0, conflict_1;

    int checks   = 0;
    int failures = 0;

    // Reference state per configuration: index 0 = zero reg + bypass, index 1 = neither.
    logic [15:0] m_mem  [2][8];
    logic        m_pend [2][8];
    logic [63:0] exp_data  [2];
    logic [3:0]  exp_valid [2];
    logic [3:0]  exp_pend  [2];
    logic        exp_conf  [2];

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_0 (
        .clk(clk), .rst(rst), .rdEn(rdEn), .rdAddr(rdAddr),
        .rdData(rd_data_0), .rdValid(rd_valid_0), .rdPending(rd_pend_0),
        .wrtEnableA(wrtEnableA), .wrtAddrA(wrtAddrA), .wrtDataA(wrtDataA),
        .wrtEnableB(wrtEnableB), .wrtAddrB(wrtAddrB), .wrtDataB(wrtDataB),
        .rsvEnable(rsvEnable), .rsvAddr(rsvAddr), .wrtConflict(conflict_0)
    );

    regfile_mp #(.NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_1 (
        .clk(clk), .rst(rst), .rdEn(rdEn), .rdAddr(rdAddr),
        .rdData(rd_data_1), .rdValid(rd_valid_1), .rdPending(rd_pend_1),
        .wrtEnableA(wrtEnableA), .wrtAddrA(wrtAddrA), .wrtDataA(wrtDataA),
        .wrtEnableB(wrtEnableB), .wrtAddrB(wrtAddrB), .wrtDataB(wrtDataB),
        .rsvEnable(rsvEnable), .rsvAddr(rsvAddr), .wrtConflict(conflict_1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rdEn = '0; rdAddr = '0;
        wrtEnableA = 1'b0; wrtAddrA = '0; wrtDataA = '0;
        wrtEnableB = 1'b0; wrtAddrB = '0; wrtDataB = '0;
        rsvEnable = 1'b0; rsvAddr = '0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[c][i]  = '0;
                m_pend[c][i] = 1'b0;
            end
            exp_data[c] = '0; exp_valid[c] = '0; exp_pend[c] = '0; exp_conf[c] = 1'b0;
        end
    endtask

    // Applies one clock edge of architectural behaviour to both reference configurations.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            logic        zr, bp, a_ok, b_ok, r_ok, p;
            logic [15:0] nmem [8];
            logic        npend [8];
            logic [2:0]  ad;
            logic [15:0] d;
            zr   = (c == 0);
            bp   = (c == 0);
            a_ok = wrtEnableA && !(zr && wrtAddrA == 3'd0);
            b_ok = wrtEnableB && !(zr && wrtAddrB == 3'd0);
            r_ok = rsvEnable && !(zr && rsvAddr == 3'd0);
            for (int i = 0; i < 8; i++) begin
                nmem[i]  = m_mem[c][i];
                npend[i] = m_pend[c][i];
            end
            if (a_ok) begin nmem[wrtAddrA] = wrtDataA; npend[wrtAddrA] = 1'b0; end
            if (b_ok) begin nmem[wrtAddrB] = wrtDataB; npend[wrtAddrB] = 1'b0; end
            if (r_ok) npend[rsvAddr] = 1'b1;
            exp_conf[c]  = a_ok && b_ok && (wrtAddrA == wrtAddrB);
            exp_valid[c] = rdEn;
            for (int k = 0; k < 4; k++) begin
                if (rdEn[k]) begin
                    ad = rdAddr[k*3 +: 3];
                    if (zr && ad == 3'd0) begin
                        d = '0; p = 1'b0;
                    end else if (bp) begin
                        d = nmem[ad]; p = npend[ad];
                    end else begin
                        d = m_mem[c][ad]; p = m_pend[c][ad];
                    end
                    exp_data[c][k*16 +: 16] = d;
                    exp_pend[c][k] = p;
                end
            end
            for (int i = 0; i < 8; i++) begin
                m_mem[c][i]  = nmem[i];
                m_pend[c][i] = npend[i];
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_d0_data"}, rd_data_0, exp_data[0]);
        chk({tag, "_d0_valid"}, 64'(rd_valid_0), 64'(exp_valid[0]));
        chk({tag, "_d0_pend"}, 64'(rd_pend_0), 64'(exp_pend[0]));
        chk({tag, "_d0_conf"}, 64'(conflict_0), 64'(exp_conf[0]));
        chk({tag, "_d1_data"}, rd_data_1, exp_data[1]);
        chk({tag, "_d1_valid"}, 64'(rd_valid_1), 64'(exp_valid[1]));
        chk({tag, "_d1_pend"}, 64'(rd_pend_1), 64'(exp_pend[1]));
        chk({tag, "_d1_conf"}, 64'(conflict_1), 64'(exp_conf[1]));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    task automatic rd0(input logic [2:0] a);
        rdEn = 4'b0001; rdAddr = {9'd0, a};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation
        wrtEnableA = 1'b1; wrtAddrA = 3'd3; wrtDataA = 16'h1234;
        cycle("wr_r3");
        rd0(3'd3);
        cycle("rd_r3");
        chk("rd_r3_before_reset", 64'(rd_data_0[15:0]), 64'h1234);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        chk("async_reset_data", rd_data_0, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        rd0(3'd3);
        cycle("rd_r3_after_reset");
        chk("r3_cleared", 64'(rd_data_1[15:0]), 64'h0);

        // Basic dual write, quad read
        wrtEnableA = 1'b1; wrtAddrA = 3'd1; wrtDataA = 16'hAAAA;
        wrtEnableB = 1'b1; wrtAddrB = 3'd2; wrtDataB = 16'h5555;
        cycle("wr_r1_r2");
        rdEn = 4'b1111; rdAddr = {3'd2, 3'd1, 3'd2, 3'd1};
        cycle("rd_quad");
        chk("quad_data", rd_data_0, 64'h5555_AAAA_5555_AAAA);
        chk("quad_valid", 64'(rd_valid_0), 64'hF);
        chk("quad_data_nobyp", rd_data_1, 64'h5555_AAAA_5555_AAAA);

        // Same-address conflict
        wrtEnableA = 1'b1; wrtAddrA = 3'd4; wrtDataA = 16'h1111;
        wrtEnableB = 1'b1; wrtAddrB = 3'd4; wrtDataB = 16'h2222;
        cycle("conflict");
        chk("conflict_high", 64'(conflict_0), 64'h1);
        rd0(3'd4);
        cycle("conflict_after");
        chk("conflict_low", 64'(conflict_0), 64'h0);
        chk("conflict_b_wins", 64'(rd_data_1[15:0]), 64'h2222);

        // Bypass versus pre-write read
        wrtEnableA = 1'b1; wrtAddrA = 3'd5; wrtDataA = 16'h0101;
        cycle("wr_r5_old");
        wrtEnableB = 1'b1; wrtAddrB = 3'd5; wrtDataB = 16'hBEEF;
        rd0(3'd5);
        cycle("bypass");
        chk("bypass_new", 64'(rd_data_0[15:0]), 64'hBEEF);
        chk("nobypass_old", 64'(rd_data_1[15:0]), 64'h0101);

        // Zero register, including a conflicting write pair to r0
        wrtEnableA = 1'b1; wrtAddrA = 3'd0; wrtDataA = 16'hFFFF;
        rsvEnable = 1'b1; rsvAddr = 3'd0;
        cycle("wr_r0");
        rd0(3'd0);
        cycle("rd_r0");
        chk("zero_data", 64'(rd_data_0[15:0]), 64'h0);
        chk("zero_pend", 64'(rd_pend_0[0]), 64'h0);
        chk("nozero_data", 64'(rd_data_1[15:0]), 64'hFFFF);
        wrtEnableA = 1'b1; wrtAddrA = 3'd0; wrtDataA = 16'h0001;
        wrtEnableB = 1'b1; wrtAddrB = 3'd0; wrtDataB = 16'h0002;
        cycle("zero_conflict");
        chk("zero_no_conflict", 64'(conflict_0), 64'h0);

        // Scoreboard
        rsvEnable = 1'b1; rsvAddr = 3'd6;
        cycle("rsv_r6");
        rd0(3'd6);
        cycle("rd_r6_pend");
        chk("r6_pending", 64'(rd_pend_0[0]), 64'h1);
        wrtEnableB = 1'b1; wrtAddrB = 3'd6; wrtDataB = 16'h0042;
        rsvEnable = 1'b1; rsvAddr = 3'd6;
        cycle("wr_rsv_r6");
        rd0(3'd6);
        cycle("rd_r6_rsv_wins");
        chk("r6_data", 64'(rd_data_0[15:0]), 64'h0042);
        chk("r6_rsv_wins", 64'(rd_pend_0[0]), 64'h1);
        wrtEnableA = 1'b1; wrtAddrA = 3'd6; wrtDataA = 16'h0043;
        cycle("wr_r6");
        rd0(3'd6);
        cycle("rd_r6_clear");
        chk("r6_cleared", 64'(rd_pend_0[0]), 64'h0);
        chk("r6_cleared_nobyp", 64'(rd_pend_1[0]), 64'h0);

        // Randomized traffic with the reference model
        for (int n = 0; n < 400; n++) begin
            rdEn       = 4'($urandom);
            rdAddr     = 12'($urandom);
            wrtEnableA = 1'($urandom);
            wrtAddrA   = 3'($urandom);
            wrtDataA   = 16'($urandom);
            wrtEnableB = 1'($urandom);
            wrtAddrB   = ($urandom_range(0, 3) == 0) ? wrtAddrA : 3'($urandom);
            wrtDataB   = 16'($urandom);
            rsvEnable  = ($urandom_range(0, 2) == 0);
            rsvAddr    = ($urandom_range(0, 3) == 0) ? wrtAddrB : 3'($urandom);
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write, double-read file.
- Configurable read-port count, two write ports, optional hard-wired zero register, optional write-to-read bypass.
- Per-register pending scoreboard for simple pipelined datapaths.
- Sits between decode/issue (read and reserve) and writeback (write).

Parameters:
WORD_SIZE, 16, data width in bits
ADDR_SIZE, 3, register address width
REG_MAX, 2**ADDR_SIZE, number of registers
NUM_RD, 2, number of read ports (1..8)
ZERO_REG, 1, 1 = register 0 always reads 0; writes and reserves to it are ignored
BYPASS, 1, 1 = same-cycle write data forwarded to the read result

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rdEn  in  NUM_RD  per-port read request
rdAddr  in  NUM_RD*ADDR_SIZE  read addresses; port k at bits [k*ADDR_SIZE +: ADDR_SIZE]
rdData  out  NUM_RD*WORD_SIZE  registered read data; port k at bits [k*WORD_SIZE +: WORD_SIZE]
rdValid  out  NUM_RD  rdData for port k updated last cycle
rdPending  out  NUM_RD  registered pending bit of the register read by port k
wrtEnableA  in  1  write port A enable
wrtAddrA  in  ADDR_SIZE  write port A address
wrtDataA  in  WORD_SIZE  write port A data
wrtEnableB  in  1  write port B enable (priority port)
wrtAddrB  in  ADDR_SIZE  write port B address
wrtDataB  in  WORD_SIZE  write port B data
rsvEnable  in  1  mark register as awaiting a result
rsvAddr  in  ADDR_SIZE  register to reserve
wrtConflict  out  1  registered one-cycle pulse: A and B wrote the same address

Behaviour:
- Reset is asynchronous and active-high. Clock is clk; reset is rst.
- On rst assertion, immediately clear: all registers, rdData, rdValid, rdPending, all pending bits, and wrtConflict.
- All state updates on the rising edge of clk when rst is low.
- Writes: an enabled port writes its address at the edge.
- Same-address write from A and B in one cycle: B's data is stored and wrtConflict pulses high for one cycle. A different-address A+B write stores both.
- ZERO_REG=1: writes to address 0 are dropped and never raise wrtConflict.
- Reads, latency 1: rdEn[k] at edge N gives rdData[k] and rdPending[k] valid after edge N, with rdValid[k]=1 for that cycle.
- rdEn[k]=0: rdData[k] and rdPending[k] hold their previous values; rdValid[k]=0.
- BYPASS=1: a read of an address written in the same cycle returns the new data (B over A). rdPending reflects the post-write state.
- BYPASS=0: the read returns the pre-write contents and pre-write pending bit.
- ZERO_REG=1: address 0 always reads 0 with pending 0.
- Scoreboard: rsvEnable sets pending[rsvAddr]. Any write (A or B) clears pending[wrtAddr].
- Reserve and write to the same address in one cycle: the data is stored and pending ends set, so reserve wins (new producer).
- Reserve of an already-pending register keeps it pending. Reserve of address 0 is ignored when ZERO_REG=1.
- All read ports are independent. Any ports may read the same address simultaneously.
- No combinational path from any input to any output.

Decomposition:
- Package regfile_pkg: default WORD_SIZE/ADDR_SIZE constants, the NUM_RD upper bound, and helper functions for extracting port-k address/data slices.
- Sub-module regfile_rd_port, instantiated NUM_RD times via generate: bypass mux, zero-register mask, and output registers for rdData/rdValid/rdPending.
- Storage, write arbitration and scoreboard stay in the top level.

Test Plan:
- Reset mid-operation: write 0x1234 to r3, then assert rst asynchronously between edges -> rdData, rdValid and wrtConflict are 0 immediately. A later read of r3 returns 0x0000.
- Basic write/read, NUM_RD=4: write r1=0xAAAA and r2=0x5555 via A and B in one cycle; next cycle all four ports read r1,r2,r1,r2 -> one cycle later rdData = AAAA,5555,AAAA,5555 and rdValid=4'b1111.
- Conflict: A writes r4=0x1111 and B writes r4=0x2222 together -> r4 holds 0x2222 and wrtConflict is high for exactly one cycle.
- Bypass: BYPASS=1, write r5=0xBEEF while port 0 reads r5 in the same cycle -> rdData[0]=0xBEEF next cycle. BYPASS=0 -> returns the old r5 value.
- Zero register: ZERO_REG=1, write r0=0xFFFF and reserve r0 -> reading r0 gives 0x0000 with rdPending=0. ZERO_REG=0 -> reads back 0xFFFF.
- Scoreboard: reserve r6 -> next read shows rdPending=1. Write r6=0x0042 with a simultaneous reserve r6 -> read gives 0x0042 and pending=1. A plain write r6 -> pending=0.
